// File: rtl/i2s_tx_if.sv
// Upstream sample-pair handshake into the I2S transmitter.
// A pair transfers on any clk edge where sample_valid && sample_ready.
interface i2s_tx_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] left_in;
  logic [WIDTH-1:0] right_in;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output left_in,
    output right_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S DAC transmitter, 64-bck frame; one held pair feeds the shifter at each 63->0 wrap (MSB one bck after load).
// Ready is low while a pair is held; I2S_TX_UNDERRUN_HOLD_EN repeats the last pair on underrun instead of silence.
module i2s_tx #(
  parameter int WIDTH   = 24,
  parameter int BCK_DIV = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  i2s_tx_if.slave  smp,
  output logic     scki,
  output logic     bck,
  output logic     lrck,
  output logic     dout,
  output logic     frame_start,
  output logic     underrun
);

  localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

  logic [DW-1:0]    div_q, div_d;
  logic             bck_q, bck_d;
  logic             scki_q;
  logic [5:0]       bitcnt_q, bitcnt_d;
  logic             lrck_q, lrck_d;
  logic             dout_q, dout_d;
  logic             fs_q, fs_d;
  logic             ur_q, ur_d;
  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] hold_l_q, hold_r_q;
  logic [WIDTH-1:0] act_l_q, act_l_d;
  logic [WIDTH-1:0] act_r_q, act_r_d;

  logic             tick, fall, load, accept;
  logic [4:0]       slot;
  logic [4:0]       bit_idx;
  logic [WIDTH-1:0] word, shifted;

  always_comb begin
    tick     = (div_q == DIV_LAST);
    fall     = tick && bck_q;
    load     = fall && (bitcnt_q == 6'd63);
    accept   = smp.sample_valid && ready_q;

    div_d    = tick ? '0 : div_q + 1'b1;
    bck_d    = tick ? ~bck_q : bck_q;
    bitcnt_d = fall ? bitcnt_q + 6'd1 : bitcnt_q;

    act_l_d  = act_l_q;
    act_r_d  = act_r_q;
    if (load) begin
      if (full_q) begin
        act_l_d = hold_l_q;
        act_r_d = hold_r_q;
      end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        act_l_d = act_l_q;
        act_r_d = act_r_q;
`else
        act_l_d = '0;
        act_r_d = '0;
`endif
      end
    end

    // Slot index is the post-increment count, so dout lags the slot boundary by one bck.
    slot    = bitcnt_d[4:0];
    word    = bitcnt_d[5] ? act_r_q : act_l_q;
    bit_idx = 5'(WIDTH - int'(slot));
    shifted = word >> bit_idx;

    lrck_d = lrck_q;
    dout_d = dout_q;
    if (fall) begin
      lrck_d = bitcnt_d[5];
      dout_d = (slot != 5'd0 && int'(slot) <= WIDTH) ? shifted[0] : 1'b0;
    end

    fs_d   = load;
    ur_d   = load && !full_q;

    full_d = full_q;
    if (load)   full_d = 1'b0;
    if (accept) full_d = 1'b1;
    ready_d = !full_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      bck_q    <= 1'b0;
      scki_q   <= 1'b0;
      bitcnt_q <= '0;
      lrck_q   <= 1'b0;
      dout_q   <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
      full_q   <= 1'b0;
      ready_q  <= 1'b1;
      hold_l_q <= '0;
      hold_r_q <= '0;
      act_l_q  <= '0;
      act_r_q  <= '0;
    end else begin
      div_q    <= div_d;
      bck_q    <= bck_d;
      scki_q   <= ~scki_q;
      bitcnt_q <= bitcnt_d;
      lrck_q   <= lrck_d;
      dout_q   <= dout_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
      full_q   <= full_d;
      ready_q  <= ready_d;
      act_l_q  <= act_l_d;
      act_r_q  <= act_r_d;
      if (accept) begin
        hold_l_q <= smp.left_in;
        hold_r_q <= smp.right_in;
      end
    end
  end

  assign smp.sample_ready = ready_q;
  assign scki        = scki_q;
  assign bck         = bck_q;
  assign lrck        = lrck_q;
  assign dout        = dout_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S transmitter: the playback-side counterpart of the codec-facing `i2s` receiver. Accepts stereo sample pairs through a valid/ready handshake, double-buffers one pair, and generates `scki`, `bck`, `lrck` and serial `dout` for an I2S DAC. All codec clocks are derived from `clk`, with a fixed 64-bck frame of 32 slots per channel.

## Interface
- `WIDTH`, 24: bits per channel sample, MSB-first, two's complement; legal range 1..31.
- `BCK_DIV`, 4: `clk` cycles per `bck` half-period; minimum 1.
- `clk` in 1: system clock; all flops on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `left_in` in WIDTH: left sample, captured on handshake.
- `right_in` in WIDTH: right sample, captured with `left_in`.
- `sample_valid` in 1: the upstream stage presents a pair.
- `sample_ready` out 1: the holding register is empty; a pair is accepted when `sample_valid && sample_ready`.
- `scki` out 1: codec system clock, `clk`/2.
- `bck` out 1: bit clock, `clk`/(2·BCK_DIV).
- `lrck` out 1: word select; 0 = left, 1 = right.
- `dout` out 1: serial data.
- `frame_start` out 1: one-`clk` pulse when a frame is loaded into the shifter.
- `underrun` out 1: one-`clk` pulse, coincident with `frame_start`, when the holding register was empty at load.

## Operation
- **Divider.**
  - `div` counts 0..BCK_DIV-1 on every `clk`.
  - When `div == BCK_DIV-1`, `div` wraps to 0 and `bck` toggles.
  - A toggle 1→0 is a *falling event*.
  - `scki` toggles every `clk`.
- **Bit counter.**
  - 6-bit `bitcnt` increments on each falling event and wraps from 63 to 0.
  - `lrck` is registered as the new `bitcnt[5]` on the same edge.
  - Slot `k` = `bitcnt[4:0]`.
- **Data (I2S, one-bck delay).**
  - On each falling event, `dout` is set to bit `WIDTH-k` of the current channel word for slots 1..WIDTH.
  - `dout` is 0 for slot 0 and for slots WIDTH+1..31.
  - `dout`, `lrck` and `bck` change on the same `clk` edge. The DAC samples on the `bck` rising edge.
- **Holding register.**
  - One pair plus a `full` flag.
  - `sample_ready = !full`, registered.
  - A handshake sets `full` and captures both samples.
- **Frame load.**
  - Occurs on the falling event where `bitcnt` wraps 63→0.
  - If `full`: the active left/right words are loaded from the holding register, `full` is cleared, and `frame_start` pulses.
  - If empty: `frame_start` and `underrun` both pulse, and the active words follow the Configuration section.
- **Simultaneous load and handshake.**
  - With `full=1`, `sample_ready` is 0, so no accept is possible that cycle. `sample_ready` rises the cycle after the load.
  - With `full=0`: the pair is accepted into holding, but this frame is still an underrun. The pair plays in the next frame.
- **First frame after reset.** The active words are 0. No load event occurs until the first 63→0 wrap, so `underrun` does not assert during the first frame.
- **Reset mid-frame.** The block returns immediately to reset state. The partial frame is discarded, and so is a held pair.

## Timing
- Reset values:
  - `bck`, `lrck`, `scki`, `dout`, `frame_start`, `underrun` = 0.
  - `sample_ready` = 1.
  - `div` = 0, `bitcnt` = 0, `full` = 0, active words = 0.
- The first `bck` rise occurs BCK_DIV cycles after reset release. The first falling event occurs at 2·BCK_DIV cycles.
- `bck` period: 2·BCK_DIV `clk`. Frame period: 128·BCK_DIV `clk`. `lrck` has a 50% duty cycle.
- Handshake-to-`dout` latency: the MSB appears one falling event after the next frame load.

## Configuration
- `I2S_TX_UNDERRUN_HOLD_EN` defined: on underrun, the active words keep their previous values, so the last pair repeats.
- Not defined: on underrun, the active words are cleared to 0, so the output is silence.
- `underrun` pulses in both builds.

## Test plan
- **Clock ratios** (BCK_DIV=4): reset released, sample stream running → `bck` period 8 `clk`, `lrck` period 512 `clk`, `scki` period 2 `clk`.
- **Bit order**: handshake left=0xA5A5A5, right=0x123456 → following frame left slots 1..24 = 101001011010010110100101, right slots 1..24 = 0x123456 MSB-first, all other slots 0.
- **Backpressure**: two back-to-back pairs → `sample_ready` 0 after the first pair until the next `frame_start`; second pair plays in the frame after the first.
- **Underrun**: one pair 0x7FFFFF/0x800000, then none → `underrun` pulse at the next load; repeated 0x7FFFFF/0x800000 with the macro, zeros without.
- **Load/handshake coincidence**: `sample_valid` rising on the load cycle with holding empty → `underrun`=1, and the pair plays in the following frame.
- **Reset mid-frame**: assert `reset_n`=0 at slot 10 of right → all outputs at reset values within the same cycle, then a clean restart with zero first frame and no `underrun`.
